// File: rtl/multi_key_beep_pkg.sv
// multi_key_beep_pkg: beep FSM states and counter width helper
package multi_key_beep_pkg;
    typedef enum logic {IDLE, TONE} state_t;
    function automatic int unsigned cw(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction
endpackage

// File: rtl/key_filter_ch.sv
// key_filter_ch: one key channel with 2-flop synchroniser, debounce and press flag
module key_filter_ch
    import multi_key_beep_pkg::*;
#(
    parameter int CNT_MAX = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key,
    output logic key_level,
    output logic key_flag
);
    localparam int CW = cw(CNT_MAX);
    logic r_s1, r_s2, r_lvl, r_lvl_d, r_flag;
    logic [CW-1:0] r_cnt;
    logic w_diff, w_done;
    assign w_diff = r_s2 != r_lvl;
    assign w_done = w_diff && (r_cnt == CW'(CNT_MAX - 1));
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_lvl   <= 1'b1;
            r_lvl_d <= 1'b1;
            r_flag  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= key;
            r_s2    <= r_s1;
            r_lvl_d <= r_lvl;
            r_flag  <= r_lvl_d & ~r_lvl;
            r_cnt   <= (!w_diff || w_done) ? '0 : r_cnt + 1'b1;
            if (w_done) r_lvl <= r_s2;
        end
    end
    assign key_level = r_lvl;
    assign key_flag  = r_flag;
endmodule

// File: rtl/multi_key_beep.sv
// multi_key_beep: debounced keys trigger a timed square-wave burst whose pitch depends on the key
module multi_key_beep
    import multi_key_beep_pkg::*;
#(
    parameter int KEY_NUM   = 4,
    parameter int CNT_MAX   = 1_000_000,
    parameter int TONE_BASE = 25_000,
    parameter int BURST_LEN = 10_000_000,
    parameter int RETRIG    = 1
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [KEY_NUM-1:0]         key,
    output logic [KEY_NUM-1:0]         key_level,
    output logic [KEY_NUM-1:0]         key_flag,
    output logic                       beep,
    output logic                       busy,
    output logic [cw(KEY_NUM)-1:0]     active_ch
);
    localparam int CHW = cw(KEY_NUM);
    localparam int TW  = cw(TONE_BASE * KEY_NUM);
    localparam int BW  = cw(BURST_LEN);
    state_t r_state, w_state_nxt;
    logic [TW-1:0] r_tone, w_tone_nxt, w_half_m1;
    logic [BW-1:0] r_burst, w_burst_nxt;
    logic [CHW-1:0] r_ch, w_ch_nxt, w_sel;
    logic r_beep, w_beep_nxt, w_trig;
    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_filter_ch #(.CNT_MAX(CNT_MAX)) u_ch (
            .sys_clk  (sys_clk),
            .sys_rst  (sys_rst),
            .key      (key[i]),
            .key_level(key_level[i]),
            .key_flag (key_flag[i])
        );
    end
    always_comb begin
        w_sel = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) if (key_flag[i]) w_sel = CHW'(i);
    end
    assign w_half_m1 = TW'(TONE_BASE * (int'(r_ch) + 1) - 1);
    // in TONE only RETRIG lets a new press win over the normal count/return path
    assign w_trig = (|key_flag) && (r_state == IDLE || RETRIG != 0);
    always_comb begin
        w_state_nxt = r_state;
        w_tone_nxt  = r_tone + 1'b1;
        w_burst_nxt = r_burst + 1'b1;
        w_beep_nxt  = r_beep;
        w_ch_nxt    = r_ch;
        if (w_trig) begin
            w_state_nxt = TONE;
            w_ch_nxt    = w_sel;
            w_tone_nxt  = '0;
            w_burst_nxt = '0;
            w_beep_nxt  = 1'b1;
        end else if (r_state == IDLE || r_burst == BW'(BURST_LEN - 1)) begin
            w_state_nxt = IDLE;
            w_tone_nxt  = '0;
            w_burst_nxt = '0;
            w_beep_nxt  = 1'b0;
        end else if (r_tone == w_half_m1) begin
            w_tone_nxt = '0;
            w_beep_nxt = ~r_beep;
        end
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= IDLE;
            r_tone  <= '0;
            r_burst <= '0;
            r_beep  <= 1'b0;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tone  <= w_tone_nxt;
            r_burst <= w_burst_nxt;
            r_beep  <= w_beep_nxt;
            r_ch    <= w_ch_nxt;
        end
    end
    assign beep      = r_beep;
    assign busy      = r_state == TONE;
    assign active_ch = r_ch;
endmodule

// File: tb/tb_multi_key_beep.sv
// tb_multi_key_beep: table-driven and directed checks of multi_key_beep with RETRIG=1 and RETRIG=0
module tb_multi_key_beep;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic [3:0] lvl1, flg1, lvl0, flg0;
    logic beep1, busy1, beep0, busy0;
    logic [1:0] ch1, ch0;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_key_beep #(.KEY_NUM(4), .CNT_MAX(4), .TONE_BASE(2), .BURST_LEN(16), .RETRIG(1)) dut_rt (
        .sys_clk(clk), .sys_rst(rst), .key(key), .key_level(lvl1), .key_flag(flg1),
        .beep(beep1), .busy(busy1), .active_ch(ch1)
    );
    multi_key_beep #(.KEY_NUM(4), .CNT_MAX(4), .TONE_BASE(2), .BURST_LEN(16), .RETRIG(0)) dut_nr (
        .sys_clk(clk), .sys_rst(rst), .key(key), .key_level(lvl0), .key_flag(flg0),
        .beep(beep0), .busy(busy0), .active_ch(ch0)
    );

    typedef struct {
        int n;
        logic rst;
        logic [3:0] key, lvl, flg;
        logic beep, busy;
        logic [1:0] ch;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(input int n, input logic r, input logic [3:0] k, input logic [3:0] l,
                               input logic [3:0] f, input logic b, input logic bz, input logic [1:0] c);
        vec_t x;
        x.n = n; x.rst = r; x.key = k; x.lvl = l; x.flg = f; x.beep = b; x.busy = bz; x.ch = c;
        return x;
    endfunction

    task automatic tick(input logic r, input logic [3:0] k);
        rst = r;
        key = k;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        // reset state
        tbl.push_back(v(2, 1, 4'hF, 4'hF, 4'h0, 0, 0, 2'd0));
        // key[1] held 20 cycles: flag 7 cycles after drop, half-period 4, burst 16
        tbl.push_back(v(5, 0, 4'hD, 4'hF, 4'h0, 0, 0, 2'd0));
        tbl.push_back(v(1, 0, 4'hD, 4'hD, 4'h0, 0, 0, 2'd0));
        tbl.push_back(v(1, 0, 4'hD, 4'hD, 4'h2, 0, 0, 2'd0));
        tbl.push_back(v(4, 0, 4'hD, 4'hD, 4'h0, 1, 1, 2'd1));
        tbl.push_back(v(4, 0, 4'hD, 4'hD, 4'h0, 0, 1, 2'd1));
        tbl.push_back(v(4, 0, 4'hD, 4'hD, 4'h0, 1, 1, 2'd1));
        tbl.push_back(v(1, 0, 4'hD, 4'hD, 4'h0, 0, 1, 2'd1));
        tbl.push_back(v(3, 0, 4'hF, 4'hD, 4'h0, 0, 1, 2'd1));
        tbl.push_back(v(2, 0, 4'hF, 4'hD, 4'h0, 0, 0, 2'd1));
        tbl.push_back(v(3, 0, 4'hF, 4'hF, 4'h0, 0, 0, 2'd1));
        // 3-cycle glitch on key[0]
        tbl.push_back(v(3, 0, 4'hE, 4'hF, 4'h0, 0, 0, 2'd1));
        tbl.push_back(v(6, 0, 4'hF, 4'hF, 4'h0, 0, 0, 2'd1));
        // key[2] and key[3] together: channel 2 wins, half-period 6
        tbl.push_back(v(5, 0, 4'h3, 4'hF, 4'h0, 0, 0, 2'd1));
        tbl.push_back(v(1, 0, 4'h3, 4'h3, 4'h0, 0, 0, 2'd1));
        tbl.push_back(v(1, 0, 4'h3, 4'h3, 4'hC, 0, 0, 2'd1));
        tbl.push_back(v(6, 0, 4'h3, 4'h3, 4'h0, 1, 1, 2'd2));
        tbl.push_back(v(6, 0, 4'h3, 4'h3, 4'h0, 0, 1, 2'd2));
        tbl.push_back(v(4, 0, 4'h3, 4'h3, 4'h0, 1, 1, 2'd2));
        tbl.push_back(v(3, 0, 4'h3, 4'h3, 4'h0, 0, 0, 2'd2));
        tbl.push_back(v(5, 0, 4'hF, 4'h3, 4'h0, 0, 0, 2'd2));
        tbl.push_back(v(2, 0, 4'hF, 4'hF, 4'h0, 0, 0, 2'd2));

        foreach (tbl[k]) begin
            for (int j = 0; j < tbl[k].n; j++) begin
                tick(tbl[k].rst, tbl[k].key);
                chk($sformatf("v%0d.%0d lvl_rt", k, j), lvl1, tbl[k].lvl);
                chk($sformatf("v%0d.%0d flag_rt", k, j), flg1, tbl[k].flg);
                chk($sformatf("v%0d.%0d beep_rt", k, j), beep1, tbl[k].beep);
                chk($sformatf("v%0d.%0d busy_rt", k, j), busy1, tbl[k].busy);
                chk($sformatf("v%0d.%0d ch_rt", k, j), ch1, tbl[k].ch);
                chk($sformatf("v%0d.%0d lvl_nr", k, j), lvl0, tbl[k].lvl);
                chk($sformatf("v%0d.%0d flag_nr", k, j), flg0, tbl[k].flg);
                chk($sformatf("v%0d.%0d beep_nr", k, j), beep0, tbl[k].beep);
                chk($sformatf("v%0d.%0d busy_nr", k, j), busy0, tbl[k].busy);
                chk($sformatf("v%0d.%0d ch_nr", k, j), ch0, tbl[k].ch);
            end
        end

        // key[3] press, then key[0] press 8 cycles into the burst
        tick(1, 4'hF);
        tick(1, 4'hF);
        for (int c = 1; c <= 34; c++) begin
            tick(0, (c >= 9) ? 4'b0110 : 4'b0111);
            if (c == 7) begin
                chk("rt flag3", flg1, 4'h8);
                chk("nr flag3", flg0, 4'h8);
            end
            if (c == 8) begin
                chk("rt start beep", beep1, 1);
                chk("rt start ch", ch1, 3);
                chk("nr start ch", ch0, 3);
            end
            if (c == 15) begin
                chk("rt flag0", flg1, 4'h1);
                chk("nr beep before toggle", beep0, 1);
                chk("nr busy at flag0", busy0, 1);
            end
            if (c == 16) begin
                chk("rt retrig ch", ch1, 0);
                chk("rt retrig beep", beep1, 1);
                chk("nr ignore ch", ch0, 3);
                chk("nr ignore beep", beep0, 0);
            end
            if (c == 18) chk("rt half2 low", beep1, 0);
            if (c == 20) chk("rt half2 high", beep1, 1);
            if (c == 23) chk("nr busy last", busy0, 1);
            if (c == 24) begin
                chk("nr busy end", busy0, 0);
                chk("nr ch hold", ch0, 3);
                chk("rt busy still", busy1, 1);
            end
            if (c == 31) chk("rt busy last", busy1, 1);
            if (c == 32) begin
                chk("rt busy end", busy1, 0);
                chk("rt beep end", beep1, 0);
                chk("rt ch hold", ch1, 0);
            end
        end

        // one-cycle reset mid-burst with key[1] held
        tick(1, 4'hF);
        tick(1, 4'hF);
        for (int c = 1; c <= 24; c++) begin
            tick(c == 12, 4'hD);
            if (c == 8) begin
                chk("rst pre busy", busy1, 1);
                chk("rst pre ch", ch1, 1);
            end
            if (c == 12) begin
                chk("rst beep", beep1, 0);
                chk("rst busy", busy1, 0);
                chk("rst ch", ch1, 0);
                chk("rst lvl", lvl1, 4'hF);
                chk("rst nr busy", busy0, 0);
            end
            if (c >= 13 && c <= 18) chk($sformatf("rst noflag c%0d", c), flg1, 4'h0);
            if (c == 17) chk("rst lvl still high", lvl1, 4'hF);
            if (c == 18) chk("rst lvl low", lvl1, 4'hD);
            if (c == 19) chk("rst flag1", flg1, 4'h2);
            if (c == 20) begin
                chk("rst rebusy", busy1, 1);
                chk("rst rebeep", beep1, 1);
                chk("rst rech", ch1, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/multi_key_beep.md
MULTI_KEY_BEEP -- requirements
Module: multi_key_beep

Interface
REQ-001 Parameter KEY_NUM, default 4: number of independent key channels (1..16).
REQ-002 Parameter CNT_MAX, default 1_000_000: debounce stability window in sys_clk cycles (>=2).
REQ-003 Parameter TONE_BASE, default 25_000: half-period unit; channel i tone half-period = TONE_BASE*(i+1) cycles.
REQ-004 Parameter BURST_LEN, default 10_000_000: tone burst duration in cycles (>=1).
REQ-005 Parameter RETRIG, default 1: 1 = a new press during a burst restarts it; 0 = presses during a burst are ignored.
REQ-006 sys_clk  input  1  single clock; all logic on its rising edge.
REQ-007 sys_rst  input  1  synchronous, active-high reset.
REQ-008 key  input  KEY_NUM  raw asynchronous keys, active-low (0 = pressed).
REQ-009 key_level  output  KEY_NUM  debounced key level, active-low.
REQ-010 key_flag  output  KEY_NUM  one-cycle pulse per debounced press (1->0 of key_level).
REQ-011 beep  output  1  buzzer drive, active-high square wave.
REQ-012 busy  output  1  high while a burst is in progress.
REQ-013 active_ch  output  clog2(KEY_NUM) (min 1)  index of the channel owning the current/last burst.

Function
REQ-014 Each key bit SHALL pass through a 2-flop synchroniser before debounce.
REQ-015 Per channel: counter clears when synced key == key_level, else increments; at CNT_MAX-1 key_level takes synced value and counter clears.
REQ-016 Pulses shorter than CNT_MAX cycles SHALL never change key_level.
REQ-017 key_flag[i] SHALL be high exactly the cycle after key_level[i] goes 1->0; releases produce no flag.
REQ-018 Press latency, raw key low to key_flag high: CNT_MAX+3 cycles.
REQ-019 Beep FSM states: IDLE, TONE.
REQ-020 IDLE: beep=0, busy=0; any key_flag -> TONE next cycle, active_ch = lowest set index, tone and burst counters = 0, beep starts at 1.
REQ-021 TONE: tone counter reaching TONE_BASE*(active_ch+1)-1 toggles beep and clears; burst counter increments each cycle.
REQ-022 TONE: burst counter reaching BURST_LEN-1 -> IDLE, beep=0 the next cycle; active_ch holds its value.
REQ-023 Simultaneous flags: lowest index wins; other flags in that cycle are discarded.
REQ-024 RETRIG=1: key_flag in TONE reloads active_ch (lowest index) and clears both counters; beep=1 next cycle.
REQ-025 RETRIG=0: key_flag in TONE is ignored; key_flag on the IDLE-return cycle is also ignored.
REQ-026 Counter widths SHALL be sized with clog2 of their maximum value; no wrap-around occurs inside a burst.

Reset
REQ-027 On sys_rst: synchronisers and key_level = all ones, debounce counters = 0, key_flag = 0, FSM = IDLE, beep = 0, busy = 0, active_ch = 0.
REQ-028 Reset asserted mid-burst SHALL force beep=0 on the next edge; no press is remembered across reset.
REQ-029 The first cycles after reset SHALL not produce key_flag, even if keys are held low (press recognised only after the full debounce window).

Structure
REQ-030 Package multi_key_beep_pkg holds the FSM state enum (IDLE, TONE) and a width helper constant function.
REQ-031 One sub-module, key_filter_ch: single-channel synchroniser, debouncer and press-flag generator, instantiated KEY_NUM times via generate.

Verification (KEY_NUM=4, CNT_MAX=4, TONE_BASE=2, BURST_LEN=16, unless noted)
REQ-032 Hold key[1] low 20 cycles -> key_flag[1] single pulse 7 cycles after the drop; beep half-period 4 cycles for 16 cycles; busy high 16 cycles; active_ch=1.
REQ-033 3-cycle low glitch on key[0] -> key_level unchanged, no key_flag, beep stays 0.
REQ-034 key[2] and key[3] fall on the same cycle -> single burst, active_ch=2, half-period 6.
REQ-035 RETRIG=1: key[3] press, then key[0] press 8 cycles into burst -> burst restarts, active_ch=0, half-period 2, busy for 16 further cycles; with RETRIG=0 the second press is ignored and busy drops after the original 16 cycles.
REQ-036 sys_rst for 1 cycle mid-burst -> beep=0, busy=0 next cycle; held key needs a fresh 4-cycle window before key_flag.
